// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer and HI/LO registers for the 5-stage MIPS core.
// Runs a 32-cycle shift-add multiply and a 32-cycle restoring divide, stalling EX meanwhile.
// Optional build macro MD_FAST_MUL_EN: mult/multu use a single-cycle combinational
// multiplier instead of the iterative one (divide is unaffected).
module md_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_en,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    // r_acc: partial remainder (div) or upper product half (mult)
    // r_q:   dividend shifting into quotient (div) or multiplier shifting into lower half (mult)
    // r_b:   divisor magnitude (div) or multiplicand magnitude (mult)
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]   r_b;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_is_mul;
    logic                w_is_div;
    logic                w_signed;
    logic                w_fast_mul;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W:0]     w_shift;
    logic [DATA_W:0]     w_sub;
    logic                w_div_ok;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]   w_quo_nxt;
    logic [DATA_W:0]     w_madd;
    logic [DATA_W-1:0]   w_mhi_nxt;
    logic [DATA_W-1:0]   w_mlo_nxt;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [DATA_W-1:0]   w_quo_s;
    logic [DATA_W-1:0]   w_rem_s;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;
    logic [2*DATA_W-1:0] w_fast_prod;

    assign w_is_mul = (op == OpMult) || (op == OpMultu);
    assign w_is_div = (op == OpDiv) || (op == OpDivu);
    assign w_signed = (op == OpMult) || (op == OpDiv);

    assign w_abs_a = (w_signed && src_a[DATA_W-1]) ? ('0 - src_a) : src_a;
    assign w_abs_b = (w_signed && src_b[DATA_W-1]) ? ('0 - src_b) : src_b;

`ifdef MD_FAST_MUL_EN
    logic [2*DATA_W-1:0] w_ext_a;
    logic [2*DATA_W-1:0] w_ext_b;
    // Sign/zero extension to full width makes the truncated product correct for both forms
    assign w_ext_a     = {{DATA_W{w_signed & src_a[DATA_W-1]}}, src_a};
    assign w_ext_b     = {{DATA_W{w_signed & src_b[DATA_W-1]}}, src_b};
    assign w_fast_prod = w_ext_a * w_ext_b;
    assign w_fast_mul  = w_is_mul;
`else
    assign w_fast_prod = '0;
    assign w_fast_mul  = 1'b0;
`endif

    // Restoring divide step: a nonnegative trial difference is always below the divisor,
    // so the top bit of the difference is a clean borrow flag.
    assign w_shift   = {r_acc, r_q[DATA_W-1]};
    assign w_sub     = w_shift - {1'b0, r_b};
    assign w_div_ok  = ~w_sub[DATA_W];
    assign w_rem_nxt = w_div_ok ? w_sub[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_quo_nxt = {r_q[DATA_W-2:0], w_div_ok};

    // Shift-add multiply step: add multiplicand on LSB, then shift the 65-bit pair right
    assign w_madd    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_mhi_nxt = w_madd[DATA_W:1];
    assign w_mlo_nxt = {w_madd[0], r_q[DATA_W-1:1]};

    assign w_prod   = {w_mhi_nxt, w_mlo_nxt};
    assign w_prod_s = r_neg_q ? ('0 - w_prod) : w_prod;
    assign w_quo_s  = r_neg_q ? ('0 - w_quo_nxt) : w_quo_nxt;
    assign w_rem_s  = r_neg_r ? ('0 - w_rem_nxt) : w_rem_nxt;
    assign w_res_hi = r_is_div ? w_rem_s : w_prod_s[2*DATA_W-1:DATA_W];
    assign w_res_lo = r_is_div ? w_quo_s : w_prod_s[DATA_W-1:0];

    // Stall/handshake outputs; the stall must rise in the issue cycle itself
    always_comb begin
        stallreq = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        if (!rst) begin
            busy = (r_state == StBusy);
            if (!cancel) begin
                stallreq = (r_state == StBusy) ||
                           ((r_state == StIdle) && start_en &&
                            (w_is_div || (w_is_mul && !w_fast_mul)));
                done     = (r_state == StDone) ||
                           ((r_state == StIdle) && start_en && w_is_mul && w_fast_mul);
            end
        end
    end

    assign hi_o = rst ? '0 : r_hi;
    assign lo_o = rst ? '0 : r_lo;

    // Sequencer FSM with HI/LO and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (cancel) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start_en) begin
                        if (op == OpMthi) begin
                            r_hi <= src_a;
                        end else if (op == OpMtlo) begin
                            r_lo <= src_a;
                        end else if (w_is_mul && w_fast_mul) begin
                            r_hi <= w_fast_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_fast_prod[DATA_W-1:0];
                        end else if (w_is_div && (src_b == '0)) begin
                            // Divide by zero: defined result, no iterations
                            r_hi    <= src_a;
                            r_lo    <= '1;
                            r_state <= StDone;
                        end else if (w_is_mul || w_is_div) begin
                            r_acc    <= '0;
                            r_q      <= w_is_div ? w_abs_a : w_abs_b;
                            r_b      <= w_is_div ? w_abs_b : w_abs_a;
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                            r_neg_r  <= w_signed & src_a[DATA_W-1];
                            r_cnt    <= '0;
                            r_state  <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    r_acc <= r_is_div ? w_rem_nxt : w_mhi_nxt;
                    r_q   <= r_is_div ? w_quo_nxt : w_mlo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_cnt   <= '0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // start_en deliberately ignored so the stalled instruction cannot reissue
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_en;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq;
    logic        busy;
    logic        done;

`ifdef MD_FAST_MUL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    md_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_en (start_en),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .stallreq (stallreq),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 iterating (m_left cycles to go), 2 completion cycle
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_phi;
    logic [31:0] m_plo;

    // Values observed in the most recent step
    logic        g_stall;
    logic        g_busy;
    logic        g_done;
    logic [31:0] g_hi;
    logic [31:0] g_lo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of mult/multu/div/divu from plain arithmetic on magnitudes
    function automatic void compute(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] rh,
                                    output logic [31:0] rl);
        bit          sg;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic [31:0] q32;
        logic [31:0] r32;
        sg = (o == 3'd0) || (o == 3'd2);
        ua = (sg && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        ub = (sg && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        if (o <= 3'd1) begin
            p = ua * ub;
            if (sg && (a[31] != b[31])) p = 64'd0 - p;
            rh = p[63:32];
            rl = p[31:0];
        end else begin
            if (ub == 64'd0) begin
                rh = a;
                rl = 32'hFFFF_FFFF;
            end else begin
                q32 = 32'(ua / ub);
                r32 = 32'(ua % ub);
                rl = (sg && (a[31] != b[31])) ? (32'd0 - q32) : q32;
                rh = (sg && a[31]) ? (32'd0 - r32) : r32;
            end
        end
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance model at the rising edge
    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic c);
        logic        is_mul;
        logic        is_div;
        logic        e_stall;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        rst = r; start_en = s; op = o; src_a = a; src_b = b; cancel = c;
        is_mul = (o <= 3'd1);
        is_div = (o == 3'd2) || (o == 3'd3);
        if (r) begin
            e_stall = 0; e_busy = 0; e_done = 0; e_hi = '0; e_lo = '0;
        end else begin
            e_busy  = (m_phase == 1);
            e_stall = !c && ((m_phase == 1) ||
                      ((m_phase == 0) && s && (is_div || (is_mul && !Fast))));
            e_done  = !c && ((m_phase == 2) || ((m_phase == 0) && s && is_mul && Fast));
            e_hi = m_hi;
            e_lo = m_lo;
        end
        #4;
        g_stall = stallreq; g_busy = busy; g_done = done; g_hi = hi_o; g_lo = lo_o;
        chk("stallreq", {63'd0, stallreq}, {63'd0, e_stall});
        chk("busy", {63'd0, busy}, {63'd0, e_busy});
        chk("done", {63'd0, done}, {63'd0, e_done});
        chk("hi_o", {32'd0, hi_o}, {32'd0, e_hi});
        chk("lo_o", {32'd0, lo_o}, {32'd0, e_lo});
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_hi = '0; m_lo = '0;
        end else if (c) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                if (o == 3'd4) m_hi = a;
                else if (o == 3'd5) m_lo = a;
                else if (is_mul || is_div) begin
                    compute(o, a, b, m_phi, m_plo);
                    if (is_div && b == 32'd0) begin
                        m_hi = m_phi; m_lo = m_plo; m_phase = 2;
                    end else if (is_mul && Fast) begin
                        m_hi = m_phi; m_lo = m_plo;
                    end else begin
                        m_phase = 1; m_left = 32;
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_phi; m_lo = m_plo; m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
        #1;
    endtask

    // Issue one op, wait for its done pulse, then one idle cycle so HI/LO are visible
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int stalls);
        bit seen;
        stalls = 0;
        step(0, 1, o, a, b, 0);
        if (g_stall) stalls++;
        seen = g_done;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(0, 0, 3'd0, 32'd0, 32'd0, 0);
            if (g_stall) stalls++;
            if (g_done) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no done pulse within 60 cycles", name);
        end
        step(0, 0, 3'd0, 32'd0, 32'd0, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    int st;
    int mul_stall;
    bit seen;

    initial begin
        rst = 1; start_en = 0; op = '0; src_a = '0; src_b = '0; cancel = 0;
        mul_stall = Fast ? 0 : 33;
        @(posedge clk);
        #1;
        step(1, 0, 3'd0, 32'd0, 32'd0, 0);
        step(1, 1, 3'd2, 32'd9, 32'd2, 0);
        step(0, 0, 3'd0, 32'd0, 32'd0, 0);
        chk("reset_hi", {32'd0, g_hi}, 64'd0);
        chk("reset_lo", {32'd0, g_lo}, 64'd0);
        chk("reset_busy", {63'd0, g_busy}, 64'd0);

        run_op("divu7_2", 3'd3, 32'd7, 32'd2, st);
        chk("divu7_2_stall", 64'(st), 64'd33);
        chk("divu7_2_lo", {32'd0, g_lo}, 64'h3);
        chk("divu7_2_hi", {32'd0, g_hi}, 64'h1);

        run_op("div-7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, st);
        chk("div-7_2_lo", {32'd0, g_lo}, 64'hFFFF_FFFD);
        chk("div-7_2_hi", {32'd0, g_hi}, 64'hFFFF_FFFF);

        run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, st);
        chk("mult_stall", 64'(st), 64'(mul_stall));
        chk("mult_hi", {32'd0, g_hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, g_lo}, 64'hFFFF_FFFE);

        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, st);
        chk("multu_stall", 64'(st), 64'(mul_stall));
        chk("multu_hi", {32'd0, g_hi}, 64'h1);
        chk("multu_lo", {32'd0, g_lo}, 64'hFFFF_FFFE);

        run_op("divu_by0", 3'd3, 32'h1234, 32'd0, st);
        chk("divu_by0_stall", 64'(st), 64'd1);
        chk("divu_by0_lo", {32'd0, g_lo}, 64'hFFFF_FFFF);
        chk("divu_by0_hi", {32'd0, g_hi}, 64'h1234);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, st);
        chk("div_ovf_lo", {32'd0, g_lo}, 64'h8000_0000);
        chk("div_ovf_hi", {32'd0, g_hi}, 64'h0);

        // mthi then mtlo back to back
        step(0, 1, 3'd4, 32'hAAAA_0000, 32'd0, 0);
        chk("mthi_stall", {63'd0, g_stall}, 64'd0);
        step(0, 1, 3'd5, 32'h5555, 32'd0, 0);
        chk("mtlo_stall", {63'd0, g_stall}, 64'd0);
        chk("mthi_hi", {32'd0, g_hi}, 64'hAAAA_0000);
        step(0, 0, 3'd0, 32'd0, 32'd0, 0);
        chk("mtlo_lo", {32'd0, g_lo}, 64'h5555);

        // Cancel mid-divide: HI/LO keep their values
        step(0, 1, 3'd2, 32'd100, 32'd7, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 3'd0, 32'd0, 32'd0, 0);
        step(0, 0, 3'd0, 32'd0, 32'd0, 1);
        chk("cancel_stall", {63'd0, g_stall}, 64'd0);
        chk("cancel_done", {63'd0, g_done}, 64'd0);
        step(0, 0, 3'd0, 32'd0, 32'd0, 0);
        chk("cancel_busy", {63'd0, g_busy}, 64'd0);
        chk("cancel_hi", {32'd0, g_hi}, 64'hAAAA_0000);
        chk("cancel_lo", {32'd0, g_lo}, 64'h5555);

        // Reset mid-divide: HI/LO cleared
        step(0, 1, 3'd2, 32'd100, 32'd7, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 3'd0, 32'd0, 32'd0, 0);
        step(1, 0, 3'd0, 32'd0, 32'd0, 0);
        chk("rst_stall", {63'd0, g_stall}, 64'd0);
        step(0, 0, 3'd0, 32'd0, 32'd0, 0);
        chk("rst_busy", {63'd0, g_busy}, 64'd0);
        chk("rst_hi", {32'd0, g_hi}, 64'd0);
        chk("rst_lo", {32'd0, g_lo}, 64'd0);

        // start_en held through the completion cycle must not reissue
        seen = 0;
        step(0, 1, 3'd3, 32'd100, 32'd7, 0);
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 1, 3'd3, 32'd100, 32'd7, 0);
            if (g_done) seen = 1;
        end
        chk("hold_done_seen", {63'd0, seen}, 64'd1);
        step(0, 0, 3'd0, 32'd0, 32'd0, 0);
        chk("hold_busy", {63'd0, g_busy}, 64'd0);
        chk("hold_stall", {63'd0, g_stall}, 64'd0);
        chk("hold_lo", {32'd0, g_lo}, 64'hE);
        chk("hold_hi", {32'd0, g_hi}, 64'h2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 400) == 0, ($urandom % 3) == 0, 3'($urandom % 8),
                 pick(), pick(), ($urandom % 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequencer for the multiply/divide unit and HI/LO registers of the 5-stage MIPS core, sitting beside EX.
- Accepts mult/multu/div/divu/mthi/mtlo from EX and runs iterative multiply and divide.
- Holds the pipeline through its stallreq output while an operation is in flight.
- Exposes HI/LO for mfhi/mflo.

Parameters:
DATA_W, 32, operand and HI/LO width (only 32 supported)
CNT_W, 6, iteration counter width

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
start_en  input  1  EX holds a valid md op this cycle
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 ignored
src_a  input  32  rs value (dividend / multiplicand / mthi-mtlo data)
src_b  input  32  rt value (divisor / multiplier)
cancel  input  1  synchronous abort (exception flush)
hi_o  output  32  registered HI
lo_o  output  32  registered LO
stallreq  output  1  pipeline stall request (`Stop level)
busy  output  1  state is BUSY
done  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (and any cycle with rst=1, including mid-operation):
  - state IDLE, counter 0.
  - hi_o, lo_o, stallreq, busy and done all 0.
- States: IDLE, BUSY, DONE.
- IDLE, start_en=1, op=mthi/mtlo:
  - Write src_a into HI or LO at the clock edge.
  - stallreq stays 0; state stays IDLE.
- IDLE, start_en=1, op=mult/multu/div/divu:
  - stallreq=1 combinationally in that same cycle (T0).
  - At the T0 edge: latch magnitudes, result signs and op; counter=0; go to BUSY.
- BUSY:
  - One iteration per cycle; counter increments.
  - Divide: restoring radix-2, one quotient bit per cycle.
  - Multiply: shift-add, one multiplier bit per cycle.
  - stallreq=1 and busy=1 throughout.
  - On the 32nd iteration (counter=31), write HI/LO with sign-corrected results at the edge and go to DONE.
  - Divide: stall spans T0..T32, 33 cycles.
- DONE:
  - done=1, stallreq=0; the stalled EX instruction advances.
  - start_en is ignored in this cycle so the same instruction cannot restart.
  - Next state IDLE.
- Signed rules:
  - Operate on absolute values.
  - Product and quotient are negated when operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (div): LO=0x80000000, HI=0.
- Mult: HI = product[63:32], LO = product[31:0]. Div: LO = quotient, HI = remainder.
- Divide by zero (src_b=0, div or divu):
  - No iteration: T0 edge goes straight to DONE; stallreq=1 for T0 only.
  - LO=0xFFFFFFFF, HI=src_a. No trap.
- cancel=1:
  - From any state, go to IDLE at the edge; HI/LO unchanged; done=0.
  - stallreq=0 in that cycle.
  - cancel has priority over start_en; rst has priority over cancel.
- Ops 6/7 and start_en=0: no state change.
- hi_o/lo_o update one edge after the write. mfhi/mflo forwarding is outside this block.

Optional Feature:
- Macro MD_FAST_MUL_EN.
- Defined:
  - mult/multu use a combinational 32x32 multiplier.
  - HI/LO are written at the T0 edge; stallreq=0 for multiplies; state stays IDLE; no DONE cycle; done pulses in T0.
- Undefined: 32-cycle shift-add as above; divide behaviour is identical either way.

Test Plan:
- divu src_a=7, src_b=2:
  - stallreq high for exactly 33 cycles, then done pulse.
  - LO=0x00000003, HI=0x00000001.
- div src_a=0xFFFFFFF9 (-7), src_b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mult 0xFFFFFFFF x 2: HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands: HI=0x00000001, LO=0xFFFFFFFE. Run both with and without MD_FAST_MUL_EN; check stall length 33 vs 0.
- divu src_a=0x1234, src_b=0:
  - stallreq for 1 cycle only.
  - LO=0xFFFFFFFF, HI=0x00001234.
- mthi 0xAAAA0000 then mtlo 0x5555 on consecutive cycles:
  - No stall.
  - hi_o=0xAAAA0000 and lo_o=0x00005555 one edge after each write.
- Mid-operation aborts:
  - div started, cancel at BUSY cycle 10 → IDLE next edge, HI/LO keep prior values, stallreq 0.
  - Repeat with rst instead of cancel → HI=LO=0.
  - start_en held high during DONE → no restart.
